// File: rtl/panel_ctrl_pkg.sv
// Shared types and constants for the front-panel controller.
package panel_ctrl_pkg;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 16;

  // Architectural reset PC of the core.
  localparam logic [AddrW-1:0] PC_RESET = 8'h10;

  typedef enum logic [2:0] {
    OP_SETADDR = 3'd0,
    OP_LOAD    = 3'd1,
    OP_LOOK    = 3'd2,
    OP_SETPC   = 3'd3,
    OP_STEP    = 3'd4,
    OP_RUN     = 3'd5,
    OP_STOP    = 3'd6,
    OP_NOP     = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  function automatic logic [AddrW-1:0] addr_inc(input logic [AddrW-1:0] a);
    return a + AddrW'(1);
  endfunction

endpackage

// File: rtl/panel_ctrl_if.sv
// Front-panel command handshake plus panel-side memory request port.
interface panel_ctrl_if;
  import panel_ctrl_pkg::*;

  logic             cmd_val;
  logic             cmd_rdy;
  op_e              cmd_op;
  logic [DataW-1:0] cmd_data;

  logic             mem_val;
  logic             mem_wen;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic             mem_rdy;
  logic [DataW-1:0] mem_rdata;

  // Controller side: accepts commands, issues memory requests.
  modport slave (
    input  cmd_val, cmd_op, cmd_data, mem_rdy, mem_rdata,
    output cmd_rdy, mem_val, mem_wen, mem_addr, mem_wdata
  );

  // Environment side: issues commands, serves memory.
  modport master (
    output cmd_val, cmd_op, cmd_data, mem_rdy, mem_rdata,
    input  cmd_rdy, mem_val, mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/panel_ctrl.sv
// Front-panel controller: address/deposit/examine memory, set PC, single-step
// and run/stop the core, keeping memory access disjoint from core execution.
module panel_ctrl
  import panel_ctrl_pkg::*;
#(
  parameter logic [AddrW-1:0] START_PC = PC_RESET
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  panel_ctrl_if.slave      bus,
  input  logic             cpu_done_i,
  output logic             cpu_exec_o,
  output logic             pc_wen_o,
  output logic [AddrW-1:0] pc_o,
  output logic [AddrW-1:0] addr_o,
  output logic [DataW-1:0] data_o,
  output logic             running_o
);

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q,  addr_d;
  logic [DataW-1:0] data_q,  data_d;
  logic             wen_q,   wen_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [AddrW-1:0] pc_q,    pc_d;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, command acceptance and the combinational PC write strobe.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    bus.cmd_rdy = 1'b0;
    pc_wen_o    = 1'b0;
    pc_o        = pc_q;

    case (state_q)
      ST_IDLE: begin
        bus.cmd_rdy = 1'b1;
        if (bus.cmd_val) begin
          case (bus.cmd_op)
            OP_SETADDR: addr_d = bus.cmd_data[AddrW-1:0];
            OP_SETPC: begin
              pc_wen_o = 1'b1;
              pc_o     = bus.cmd_data[AddrW-1:0];
              pc_d     = bus.cmd_data[AddrW-1:0];
            end
            OP_LOAD, OP_LOOK: begin
              wen_d   = (bus.cmd_op == OP_LOAD);
              wdata_d = bus.cmd_data;
              state_d = ST_MEM;
            end
            OP_STEP: state_d = ST_STEP;
            OP_RUN:  state_d = ST_RUN;
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        if (bus.mem_rdy) begin
          if (!wen_q) data_d = bus.mem_rdata;
          addr_d  = addr_inc(addr_q);
          state_d = ST_IDLE;
        end
      end
      ST_STEP: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (cpu_done_i) state_d = ST_IDLE;
      end
      ST_RUN: begin
        // Only STOP is taken while running; everything else stalls.
        bus.cmd_rdy = (bus.cmd_op == OP_STOP);
        if (bus.cmd_val && (bus.cmd_op == OP_STOP)) state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_exec_o    = (state_q == ST_STEP) || (state_q == ST_RUN);
  assign running_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.mem_val   = (state_q == ST_MEM);
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign addr_o        = addr_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed self-checking bench for panel_ctrl with a behavioural memory.
module tb_panel_ctrl;
  import panel_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        cpu_done_i = 1'b0;
  logic        cpu_exec_o, pc_wen_o, running_o;
  logic [7:0]  pc_o, addr_o;
  logic [15:0] data_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  panel_ctrl_if bus ();

  panel_ctrl #(.START_PC(8'h10)) dut (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .bus        (bus),
    .cpu_done_i (cpu_done_i),
    .cpu_exec_o (cpu_exec_o),
    .pc_wen_o   (pc_wen_o),
    .pc_o       (pc_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .running_o  (running_o)
  );

  // Behavioural memory: answers after mem_delay wait cycles unless held.
  int          mem_delay = 0;
  logic        mem_hold = 1'b0;
  int          wait_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] mem [256];

  assign bus.mem_rdy   = bus.mem_val && !mem_hold && (wait_cnt >= mem_delay);
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk_i) begin
    if (bus.mem_val && bus.mem_rdy) begin
      wait_cnt <= 0;
      if (bus.mem_wen) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end else if (bus.mem_val) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // Pulse counters for the core-facing strobes.
  int         exec_cnt = 0;
  int         pcw_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_pc = 8'h00;

  always @(negedge clk_i) begin
    if (cpu_exec_o) exec_cnt <= exec_cnt + 1;
    if (pc_wen_o) begin
      pcw_cnt <= pcw_cnt + 1;
      last_pc <= pc_o;
    end
    if (cpu_exec_o && pc_wen_o) both_cnt <= both_cnt + 1;
  end

  task automatic send(input op_e op, input logic [15:0] d);
    int n;
    @(posedge clk_i); #1;
    bus.cmd_val  = 1'b1;
    bus.cmd_op   = op;
    bus.cmd_data = d;
    n = 0;
    @(negedge clk_i);
    while (!bus.cmd_rdy && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.cmd_rdy) begin
      n_total++;
      $display("FAIL send_timeout op=%0d cmd_rdy=%b want 1", op, bus.cmd_rdy);
    end
    @(posedge clk_i); #1;
    bus.cmd_val = 1'b0;
    bus.cmd_op  = OP_NOP;
  endtask

  task automatic wait_mem_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!bus.mem_val) break;
    end
    n_total++;
    if (bus.mem_val !== 1'b0) $display("FAIL mem_timeout mem_val=%b want 0", bus.mem_val);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.mem_val !== 1'b0 || cpu_exec_o !== 1'b0 || pc_wen_o !== 1'b0 || running_o !== 1'b0)
      $display("FAIL reset_ctl mem_val=%b exec=%b pc_wen=%b run=%b want 0000",
               bus.mem_val, cpu_exec_o, pc_wen_o, running_o);
    else n_pass++;
    @(negedge clk_i); arst_ni = 1'b1;
    @(negedge clk_i);
    n_total++;
    if (addr_o !== 8'h00 || data_o !== 16'h0000)
      $display("FAIL reset_regs addr=%h data=%h want 00 0000", addr_o, data_o);
    else n_pass++;
    n_total++;
    if (bus.cmd_rdy !== 1'b1) $display("FAIL reset_rdy cmd_rdy=%b want 1", bus.cmd_rdy);
    else n_pass++;
  endtask

  task automatic test_load();
    send(OP_SETADDR, 16'h0020);
    n_total++;
    if (addr_o !== 8'h20) $display("FAIL setaddr addr=%h want 20", addr_o);
    else n_pass++;
    send(OP_LOAD, 16'h1234);
    wait_mem_done();
    send(OP_LOAD, 16'hABCD);
    wait_mem_done();
    n_total++;
    if (mem[8'h20] !== 16'h1234) $display("FAIL load0 mem20=%h want 1234", mem[8'h20]);
    else n_pass++;
    n_total++;
    if (mem[8'h21] !== 16'hABCD) $display("FAIL load1 mem21=%h want abcd", mem[8'h21]);
    else n_pass++;
    n_total++;
    if (addr_o !== 8'h22 || wr_cnt !== 2) $display("FAIL load_addr addr=%h wr=%0d want 22 2", addr_o, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_look_wrap();
    int stable, bad, w0;
    send(OP_SETADDR, 16'h00FF);
    send(OP_LOAD, 16'hBEEF);
    wait_mem_done();
    n_total++;
    if (addr_o !== 8'h00) $display("FAIL wrap_load addr=%h want 00", addr_o);
    else n_pass++;
    send(OP_SETADDR, 16'h00FF);
    mem_delay = 3;
    w0 = wr_cnt;
    stable = 0;
    bad = 0;
    send(OP_LOOK, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!bus.mem_val) break;
      if (bus.mem_addr === 8'hFF) stable++;
      else bad++;
    end
    mem_delay = 0;
    n_total++;
    if (stable !== 4 || bad !== 0) $display("FAIL look_hold stable=%0d bad=%0d want 4 0", stable, bad);
    else n_pass++;
    n_total++;
    if (data_o !== 16'hBEEF) $display("FAIL look_data data=%h want beef", data_o);
    else n_pass++;
    n_total++;
    if (addr_o !== 8'h00 || wr_cnt !== w0) $display("FAIL look_wrap addr=%h wr=%0d want 00 %0d", addr_o, wr_cnt, w0);
    else n_pass++;
  endtask

  task automatic test_idle_noops();
    int e0;
    e0 = exec_cnt;
    send(OP_NOP, 16'h0055);
    send(OP_STOP, 16'h0066);
    @(negedge clk_i);
    n_total++;
    if (addr_o !== 8'h00 || running_o !== 1'b0 || exec_cnt !== e0 || bus.cmd_rdy !== 1'b1)
      $display("FAIL idle_noop addr=%h run=%b exec_d=%0d rdy=%b want 00 0 0 1",
               addr_o, running_o, exec_cnt - e0, bus.cmd_rdy);
    else n_pass++;
  endtask

  task automatic test_step();
    int e0, p0, rdy_hi;
    cpu_done_i = 1'b0;
    e0 = exec_cnt;
    p0 = pcw_cnt;
    send(OP_SETPC, 16'h0040);
    send(OP_STEP, 16'h0000);
    rdy_hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (bus.cmd_rdy !== 1'b0) rdy_hi++;
    end
    n_total++;
    if (rdy_hi !== 0 || running_o !== 1'b1) $display("FAIL step_drain rdy_hi=%0d run=%b want 0 1", rdy_hi, running_o);
    else n_pass++;
    cpu_done_i = 1'b1;
    @(posedge clk_i); #1;
    n_total++;
    if (bus.cmd_rdy !== 1'b1 || running_o !== 1'b0) $display("FAIL step_idle rdy=%b run=%b want 1 0", bus.cmd_rdy, running_o);
    else n_pass++;
    n_total++;
    if (pcw_cnt - p0 !== 1 || last_pc !== 8'h40) $display("FAIL setpc pulses=%0d pc=%h want 1 40", pcw_cnt - p0, last_pc);
    else n_pass++;
    n_total++;
    if (exec_cnt - e0 !== 1) $display("FAIL step_exec pulses=%0d want 1", exec_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_run_stop();
    int bad, w0;
    cpu_done_i = 1'b0;
    w0 = wr_cnt;
    send(OP_RUN, 16'h0000);
    bus.cmd_val  = 1'b1;
    bus.cmd_op   = OP_LOAD;
    bus.cmd_data = 16'h5555;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (bus.cmd_rdy !== 1'b0 || cpu_exec_o !== 1'b1) bad++;
    end
    n_total++;
    if (bad !== 0 || running_o !== 1'b1) $display("FAIL run_stall bad=%0d run=%b want 0 1", bad, running_o);
    else n_pass++;
    bus.cmd_op = OP_STOP;
    #1;
    n_total++;
    if (bus.cmd_rdy !== 1'b1) $display("FAIL stop_rdy cmd_rdy=%b want 1", bus.cmd_rdy);
    else n_pass++;
    @(posedge clk_i); #1;
    bus.cmd_op = OP_LOAD;
    n_total++;
    if (cpu_exec_o !== 1'b0 || running_o !== 1'b1) $display("FAIL stop_exec exec=%b run=%b want 0 1", cpu_exec_o, running_o);
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (bus.cmd_rdy !== 1'b0) $display("FAIL drain_rdy cmd_rdy=%b want 0", bus.cmd_rdy);
    else n_pass++;
    cpu_done_i = 1'b1;
    @(posedge clk_i); #1;
    n_total++;
    if (bus.cmd_rdy !== 1'b1) $display("FAIL load_after rdy=%b want 1", bus.cmd_rdy);
    else n_pass++;
    @(posedge clk_i); #1;
    bus.cmd_val = 1'b0;
    bus.cmd_op  = OP_NOP;
    wait_mem_done();
    n_total++;
    if (mem[8'h00] !== 16'h5555 || wr_cnt - w0 !== 1) $display("FAIL run_load mem00=%h wr=%0d want 5555 1", mem[8'h00], wr_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    int w0;
    mem_hold = 1'b1;
    send(OP_SETADDR, 16'h0030);
    w0 = wr_cnt;
    send(OP_LOAD, 16'h7777);
    @(negedge clk_i);
    n_total++;
    if (bus.mem_val !== 1'b1 || bus.mem_addr !== 8'h30) $display("FAIL mid_mem val=%b addr=%h want 1 30", bus.mem_val, bus.mem_addr);
    else n_pass++;
    #2 arst_ni = 1'b0;
    #1;
    n_total++;
    if (bus.mem_val !== 1'b0 || addr_o !== 8'h00 || data_o !== 16'h0000 || running_o !== 1'b0)
      $display("FAIL arst_abort val=%b addr=%h data=%h run=%b want 0 00 0000 0", bus.mem_val, addr_o, data_o, running_o);
    else n_pass++;
    mem_hold = 1'b0;
    @(negedge clk_i); arst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    n_total++;
    if (wr_cnt !== w0 || bus.mem_val !== 1'b0 || bus.cmd_rdy !== 1'b1)
      $display("FAIL arst_nowrite wr_d=%0d val=%b rdy=%b want 0 0 1", wr_cnt - w0, bus.mem_val, bus.cmd_rdy);
    else n_pass++;
  endtask

  initial begin
    bus.cmd_val  = 1'b0;
    bus.cmd_op   = OP_NOP;
    bus.cmd_data = 16'h0000;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_load();
    test_look_wrap();
    test_idle_noops();
    test_step();
    test_run_stop();
    test_reset_mid_mem();
    n_total++;
    if (both_cnt !== 0) $display("FAIL exec_pcwen_overlap count=%0d want 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/panel_ctrl.md
PANEL_CTRL -- requirements
Module: panel_ctrl

Interface
REQ-001 Parameter START_PC, 8'h10, value loaded into the PC register at reset; equals the core architectural reset PC.
REQ-002 clk_i  input  1  clock, all state updates on rising edge.
REQ-003 arst_ni  input  1  reset, asynchronous, active-low.
REQ-004 cmd_val_i  input  1  front-panel command valid.
REQ-005 cmd_op_i  input  3  opcode: 0 SETADDR, 1 LOAD, 2 LOOK, 3 SETPC, 4 STEP, 5 RUN, 6 STOP, 7 NOP.
REQ-006 cmd_data_i  input  16  switch value; [7:0] used by SETADDR/SETPC.
REQ-007 cmd_rdy_o  output  1  command accepted when cmd_val_i && cmd_rdy_o.
REQ-008 cpu_exec_o, pc_wen_o  output  1 each  drive core cpu_exec_i / pc_wen_i.
REQ-009 pc_o  output  8  drives core pc_i.
REQ-010 cpu_done_i  input  1  core has no in-flight instructions.
REQ-011 mem_val_o, mem_wen_o  output  1 each; mem_addr_o  output  8; mem_wdata_o  output  16: panel memory request.
REQ-012 mem_rdy_i  input  1; mem_rdata_i  input  16: memory response, same cycle as accept.
REQ-013 addr_o  output  8  panel address register; data_o  output  16  last LOOK data; running_o  output  1  state is RUN or DRAIN.

Function
REQ-014 States: IDLE, MEM, STEP, DRAIN, RUN.
REQ-015 cmd_rdy_o = 1 in IDLE for all ops; in RUN only for STOP (other ops stall); 0 in MEM, STEP, DRAIN.
REQ-016 SETADDR in IDLE: addr_o <= cmd_data_i[7:0] next cycle; stay IDLE.
REQ-017 SETPC in IDLE: pc_wen_o = 1 and pc_o = cmd_data_i[7:0] for exactly the one accept cycle (combinational); stay IDLE.
REQ-018 LOAD/LOOK in IDLE: latch wen and wdata; go MEM.
REQ-019 MEM: mem_val_o = 1, mem_addr_o = addr_o, held stable until mem_rdy_i; on accept: LOOK stores mem_rdata_i to data_o, addr_o increments mod 256 (8'hFF -> 8'h00), go IDLE.
REQ-020 STEP in IDLE: go STEP; STEP asserts cpu_exec_o for exactly one cycle, then go DRAIN.
REQ-021 RUN in IDLE: go RUN; cpu_exec_o = 1 every cycle in RUN.
REQ-022 STOP accepted in RUN: cpu_exec_o = 0 from the next cycle; go DRAIN.
REQ-023 DRAIN: cpu_exec_o = 0; go IDLE on the first cycle cpu_done_i = 1.
REQ-024 STOP in IDLE and NOP: accepted, no effect.
REQ-025 mem_val_o = 0 outside MEM; pc_wen_o = 0 outside IDLE; cpu_exec_o and pc_wen_o never both 1.
REQ-026 Memory access only in MEM, so it never overlaps core execution.

Reset
REQ-027 On arst_ni low: state IDLE, addr_o 0, data_o 0, latched wen/wdata 0, cpu_exec_o 0, pc_wen_o 0, mem_val_o 0, running_o 0.
REQ-028 Reset mid-MEM or mid-RUN aborts at once with no completion effects; START_PC is reset by the core, not driven via pc_wen_o.

Structure
REQ-029 Opcode enum and state enum in the shared package; START_PC default taken from the package PC reset constant.
REQ-030 Single module; no sub-modules.

Verification
REQ-031 Reset, then SETADDR 0x20, LOAD 0x1234, LOAD 0xABCD -> writes mem[0x20]=0x1234, mem[0x21]=0xABCD; addr_o=0x22.
REQ-032 SETADDR 0xFF, LOOK with mem_rdy_i delayed 3 cycles -> mem_addr_o stable at 0xFF for 4 cycles; data_o = mem[0xFF]; addr_o wraps to 0x00.
REQ-033 SETPC 0x40, then STEP -> one pc_wen_o pulse with pc_o=0x40; one cpu_exec_o pulse; cmd_rdy_o low until cpu_done_i=1.
REQ-034 RUN, LOAD issued during RUN, STOP -> LOAD stalls (cmd_rdy_o=0) while cpu_exec_o=1; STOP accepted; cpu_exec_o=0 next cycle; after DRAIN the LOAD is accepted.
REQ-035 arst_ni pulsed while in MEM with mem_rdy_i=0 -> mem_val_o=0 immediately; addr_o=0; state IDLE; no write occurs.
